// File: rtl/div_unit_if.sv
// Request/response bundle for the iterative divider: operands and control in,
// busy/done status and the quotient/remainder results out.
interface div_unit_if;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// 32-bit restoring divider for DIV/DIVU: one shift-subtract step per cycle on
// operand magnitudes, sign correction applied when the result is published.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvsr_q;
  logic        sa_q;
  logic        sb_q;
  logic        dz_q;
  logic        done_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        div_zero_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic        step_ge;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  always_comb begin
    abs_a = (bus.signed_div && bus.dividend[31]) ? (32'd0 - bus.dividend) : bus.dividend;
    abs_b = (bus.signed_div && bus.divisor[31])  ? (32'd0 - bus.divisor)  : bus.divisor;
  end

  // Partial remainder stays below the divisor, so the subtraction fits in 32 bits.
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    step_ge  = (shifted >= {1'b0, dvsr_q});
    rem_step = step_ge ? (shifted[31:0] - dvsr_q) : shifted[31:0];
    quo_step = {quo_q[30:0], step_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      dz_q        <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            sa_q   <= bus.signed_div & bus.dividend[31];
            sb_q   <= bus.signed_div & bus.divisor[31];
            quo_q  <= abs_a;
            dvsr_q <= abs_b;
            cnt_q  <= '0;
            if (bus.divisor == 32'd0) begin
              // Keep the dividend magnitude so FIN can restore it as the remainder.
              dz_q    <= 1'b1;
              rem_q   <= abs_a;
              state_q <= FIN;
            end else begin
              dz_q    <= 1'b0;
              rem_q   <= '0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.cancel) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
          if (!bus.cancel) begin
            quotient_q  <= dz_q ? '1 : ((sa_q ^ sb_q) ? (32'd0 - quo_q) : quo_q);
            remainder_q <= sa_q ? (32'd0 - rem_q) : rem_q;
            div_zero_q  <= dz_q;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: an arithmetic reference with a latency counter is
// compared against the DUT every cycle, plus literal checks on key results.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if dif();
  div_unit u_dut (.clk(clk), .rst(rst), .bus(dif));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } res_t;

  function automatic res_t ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    res_t        res;
    logic        na, nb;
    logic [31:0] ma, mb, uq, ur;
    if (b == 32'd0) begin
      res.q = 32'hFFFF_FFFF; res.r = a; res.dz = 1'b1;
    end else if (!sg) begin
      res.q = a / b; res.r = a % b; res.dz = 1'b0;
    end else begin
      na = a[31]; nb = b[31];
      ma = na ? (32'd0 - a) : a;
      mb = nb ? (32'd0 - b) : b;
      uq = ma / mb; ur = ma % mb;
      res.q  = (na ^ nb) ? (32'd0 - uq) : uq;
      res.r  = na ? (32'd0 - ur) : ur;
      res.dz = 1'b0;
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: counts down the edges left until completion while an operation is live.
  int          m_left;
  res_t        m_pend;
  logic [31:0] m_q, m_r;
  logic        m_dz, m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (dif.cancel) m_left <= 0;
        else if (m_left == 1) begin
          m_left <= 0;
          m_q <= m_pend.q; m_r <= m_pend.r; m_dz <= m_pend.dz; m_done <= 1'b1;
        end else m_left <= m_left - 1;
      end else if (dif.start && !dif.cancel) begin
        m_pend <= ref_div(dif.signed_div, dif.dividend, dif.divisor);
        m_left <= (dif.divisor == 32'd0) ? 1 : 33;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      {31'd0, dif.busy},     {31'd0, m_left != 0});
      chk("done",      {31'd0, dif.done},     {31'd0, m_done});
      chk("quotient",  dif.quotient,          m_q);
      chk("remainder", dif.remainder,         m_r);
      chk("div_zero",  {31'd0, dif.div_zero}, {31'd0, m_dz});
    end
  end

  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output res_t res, output int edges);
    bit got;
    got = 1'b0;
    @(negedge clk);
    dif.start = 1'b1; dif.signed_div = sg; dif.dividend = a; dif.divisor = b;
    edges = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      edges++;
      #1;
      dif.start      = 1'b0;
      dif.dividend   = $urandom;
      dif.divisor    = $urandom;
      dif.signed_div = 1'($urandom_range(0, 1));
      if (dif.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_timeout", {31'd0, got}, 32'd1);
    res.q = dif.quotient; res.r = dif.remainder; res.dz = dif.div_zero;
  endtask

  task automatic chk_res(input string name, input res_t res, input logic [31:0] q,
                         input logic [31:0] r, input logic dz);
    chk({name, "_q"},  res.q, q);
    chk({name, "_r"},  res.r, r);
    chk({name, "_dz"}, {31'd0, res.dz}, {31'd0, dz});
  endtask

  initial begin
    res_t res;
    int   edges;
    int   ndone;

    rst = 1'b1;
    dif.start = 1'b0; dif.cancel = 1'b0; dif.signed_div = 1'b0;
    dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, dif.busy}, 32'd0);
    chk("rst_done", {31'd0, dif.done}, 32'd0);
    chk("rst_q", dif.quotient, 32'd0);
    chk("rst_r", dif.remainder, 32'd0);
    chk("rst_dz", {31'd0, dif.div_zero}, 32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, res, edges);
    chk_res("divu_100_7", res, 32'd14, 32'd2, 1'b0);
    chk("divu_latency", 32'(edges), 32'd34);
    @(posedge clk); #1;
    chk("done_width", {31'd0, dif.done}, 32'd0);

    do_div(1'b1, 32'hFFFF_FFF9, 32'h2, res, edges);
    chk_res("div_m7_2", res, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, edges);
    chk_res("div_7_m2", res, 32'hFFFF_FFFD, 32'd1, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, edges);
    chk_res("div_ovf", res, 32'h8000_0000, 32'd0, 1'b0);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, res, edges);
    chk_res("divu_big", res, 32'd0, 32'h8000_0000, 1'b0);
    do_div(1'b0, 32'h1234, 32'd0, res, edges);
    chk_res("dz_u", res, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    chk("dz_latency", 32'(edges), 32'd2);
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, res, edges);
    chk_res("dz_s", res, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, res, edges);
    chk_res("divu_max_1", res, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, res, edges);
    chk_res("div_m100_7", res, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    // Cancel on the 10th CALC cycle, with a stray start during CALC.
    @(negedge clk);
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.dividend = 32'd1000; dif.divisor = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 32'd5; dif.divisor = 32'd1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    dif.cancel = 1'b1;
    @(posedge clk); #1;
    dif.cancel = 1'b0;
    chk("cancel_busy", {31'd0, dif.busy}, 32'd0);
    chk("cancel_q", dif.quotient, 32'hFFFF_FFF2);
    chk("cancel_r", dif.remainder, 32'hFFFF_FFFE);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dif.done) ndone++;
    end
    chk("cancel_no_done", 32'(ndone), 32'd0);

    // Cancel and start together in IDLE: start must be dropped.
    @(negedge clk);
    dif.start = 1'b1; dif.cancel = 1'b1; dif.dividend = 32'd8; dif.divisor = 32'd2;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.cancel = 1'b0;
    chk("cancel_start_idle", {31'd0, dif.busy}, 32'd0);
    repeat (3) @(posedge clk);

    // Reset mid-CALC clears everything and the next operation is clean.
    @(negedge clk);
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.dividend = 32'd50; dif.divisor = 32'd5;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstcalc_busy", {31'd0, dif.busy}, 32'd0);
    chk("rstcalc_q", dif.quotient, 32'd0);
    chk("rstcalc_r", dif.remainder, 32'd0);
    chk("rstcalc_dz", {31'd0, dif.div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_div(1'b0, 32'd9, 32'd3, res, edges);
    chk_res("divu_9_3", res, 32'd3, 32'd0, 1'b0);
    repeat (3) @(posedge clk);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
